// File: rtl/ysyx_22050243_gpr_wb_arb.sv
// ysyx_22050243_gpr_wb_arb
// Arbitrates the single GPR write port between EXU and LSU writeback.
// Each requester owns a 1-entry buffer; one buffer drains per cycle into a
// registered write stage that drives the GPR port. A combinational query port
// exposes in-flight values for decode forwarding/stall decisions.
//
// Build option:
//   GPR_WB_RR_EN  defined   -> round-robin tie break (last-granted pointer lp)
//                 undefined -> fixed priority, EXU wins every tie
module ysyx_22050243_gpr_wb_arb #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_addr,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  gpr_w_en,
    output logic [ADDR_WIDTH-1:0] gpr_w_addr,
    output logic [DATA_WIDTH-1:0] gpr_w_data,
    input  logic [ADDR_WIDTH-1:0] q_addr,
    output logic                  q_hit,
    output logic [DATA_WIDTH-1:0] q_data
);

    // One pending writeback: valid flag plus destination and value
    typedef struct packed {
        logic                  v;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_buf_t;

    wb_buf_t b0_q;
    wb_buf_t b1_q;

    logic                  tie_to_exu_c;
    logic                  grant0_c;
    logic                  grant1_c;
    logic                  grant_any_c;
    logic [ADDR_WIDTH-1:0] g_addr_c;
    logic [DATA_WIDTH-1:0] g_data_c;
    logic                  exu_fire_c;
    logic                  lsu_fire_c;

`ifdef GPR_WB_RR_EN
    // Last-granted index: 0 = EXU, 1 = LSU
    logic lp_q;

    // A tie goes to the buffer that was not granted last
    always_comb begin
        tie_to_exu_c = 1'b0;
        tie_to_exu_c = lp_q;
    end
`else
    // Fixed priority: EXU wins every tie
    always_comb begin
        tie_to_exu_c = 1'b1;
    end
`endif

    // Grant at most one valid buffer per cycle and mux its payload
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (b0_q.v && b1_q.v) begin
            grant0_c = tie_to_exu_c;
            grant1_c = ~tie_to_exu_c;
        end else begin
            grant0_c = b0_q.v;
            grant1_c = b1_q.v;
        end
        grant_any_c = grant0_c | grant1_c;
        g_addr_c    = grant1_c ? b1_q.addr : b0_q.addr;
        g_data_c    = grant1_c ? b1_q.data : b0_q.data;
    end

    // A buffer can take a new entry when empty or draining this edge; held low in reset
    assign exu_ready  = rst_n & (~b0_q.v | grant0_c);
    assign lsu_ready  = rst_n & (~b1_q.v | grant1_c);
    assign exu_fire_c = exu_valid & exu_ready;
    assign lsu_fire_c = lsu_valid & lsu_ready;

    // EXU input buffer: capture on handshake, otherwise clear when granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b0_q <= '0;
        end else if (exu_fire_c) begin
            b0_q <= {1'b1, exu_addr, exu_data};
        end else if (grant0_c) begin
            b0_q.v <= 1'b0;
        end
    end

    // LSU input buffer: capture on handshake, otherwise clear when granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b1_q <= '0;
        end else if (lsu_fire_c) begin
            b1_q <= {1'b1, lsu_addr, lsu_data};
        end else if (grant1_c) begin
            b1_q.v <= 1'b0;
        end
    end

    // Write stage: x0 grants consume the slot but never enable the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpr_w_en   <= 1'b0;
            gpr_w_addr <= '0;
            gpr_w_data <= '0;
        end else begin
            gpr_w_en <= grant_any_c && (g_addr_c != '0);
            if (grant_any_c) begin
                gpr_w_addr <= g_addr_c;
                gpr_w_data <= g_data_c;
            end
        end
    end

`ifdef GPR_WB_RR_EN
    // Remember which buffer was granted; reset points at LSU so EXU wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_q <= 1'b1;
        end else if (grant_any_c) begin
            lp_q <= grant1_c;
        end
    end
`endif

    // In-flight lookup: buffers are newer than the write stage, so they win
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        if (q_addr != '0) begin
            if (b0_q.v && (b0_q.addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = b0_q.data;
            end else if (b1_q.v && (b1_q.addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = b1_q.data;
            end else if (gpr_w_en && (gpr_w_addr == q_addr)) begin
                q_hit  = 1'b1;
                q_data = gpr_w_data;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_gpr_wb_arb.sv
// Self-checking bench for ysyx_22050243_gpr_wb_arb (either GPR_WB_RR_EN setting).
module tb_ysyx_22050243_gpr_wb_arb;

    logic        clk;
    logic        rst_n;
    logic        exu_valid;
    logic        exu_ready;
    logic [4:0]  exu_addr;
    logic [31:0] exu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        gpr_w_en;
    logic [4:0]  gpr_w_addr;
    logic [31:0] gpr_w_data;
    logic [4:0]  q_addr;
    logic        q_hit;
    logic [31:0] q_data;

    ysyx_22050243_gpr_wb_arb #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .exu_valid  (exu_valid),
        .exu_ready  (exu_ready),
        .exu_addr   (exu_addr),
        .exu_data   (exu_data),
        .lsu_valid  (lsu_valid),
        .lsu_ready  (lsu_ready),
        .lsu_addr   (lsu_addr),
        .lsu_data   (lsu_data),
        .gpr_w_en   (gpr_w_en),
        .gpr_w_addr (gpr_w_addr),
        .gpr_w_data (gpr_w_data),
        .q_addr     (q_addr),
        .q_hit      (q_hit),
        .q_data     (q_data)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic        ev;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  qa;
        logic        qhit;
        logic [31:0] qdata;
    } vec_t;

    localparam int unsigned NVEC = 8;

    vec_t vecs [NVEC];
    wr_t  exp_q[$];
    wr_t  exu_src[$];
    wr_t  lsu_src[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int wr_count = 0;
    int win_base = 0;
    int win_first = 0;
    int win_last = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every enabled GPR write must match the head of the expected queue
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (gpr_w_en === 1'b1) begin
            if (wr_count == win_base) win_first = cyc;
            win_last = cyc;
            wr_count = wr_count + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", 64'(gpr_w_addr), 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(gpr_w_addr), 64'(e.addr));
                chk("wr_data", 64'(gpr_w_data), 64'(e.data));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        exu_valid = 1'b0;
        exu_addr  = '0;
        exu_data  = '0;
        lsu_valid = 1'b0;
        lsu_addr  = '0;
        lsu_data  = '0;
    endtask

    // Hold reset two cycles, check reset outputs, release and check ready
    task automatic do_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        q_addr = 5'd5;
        rst_n  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_w_en", 64'(gpr_w_en), 64'd0);
        chk("rst_exu_ready", 64'(exu_ready), 64'd0);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd0);
        chk("rst_q_hit", 64'(q_hit), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_exu_ready", 64'(exu_ready), 64'd1);
        chk("post_rst_lsu_ready", 64'(lsu_ready), 64'd1);
    endtask

    // Wait (bounded) for all expected writes, then a few quiet cycles
    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Feed exu_src/lsu_src with full valid/ready handshakes, bounded
    task automatic stream(input bit chk_starve);
        int  ei;
        int  li;
        int  guard;
        bit  ef;
        bit  lf;
        ei = 0;
        li = 0;
        guard = 0;
        @(posedge clk);
        #1;
        while ((ei < exu_src.size() || li < lsu_src.size()) && guard < 200) begin
            exu_valid = (ei < exu_src.size());
            if (ei < exu_src.size()) begin
                exu_addr = exu_src[ei].addr;
                exu_data = exu_src[ei].data;
            end
            lsu_valid = (li < lsu_src.size());
            if (li < lsu_src.size()) begin
                lsu_addr = lsu_src[li].addr;
                lsu_data = lsu_src[li].data;
            end
            @(negedge clk);
            if (chk_starve && ei >= 1 && ei < exu_src.size())
                chk("lsu_starved", 64'(lsu_ready), 64'd0);
            ef = exu_valid && exu_ready;
            lf = lsu_valid && lsu_ready;
            @(posedge clk);
            #1;
            if (ef) ei++;
            if (lf) li++;
            guard++;
        end
        idle_inputs();
        chk("stream_done", 64'(guard < 200), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        q_addr = '0;
        idle_inputs();

        // Table of single-shot requests from an idle, freshly reset block
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd5,  1'b1, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 5'd3,  32'h11,       1'b1, 5'd4,  32'h22,       5'd4,  1'b1, 32'h22};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  32'h0,        5'd0,  1'b0, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h55,       5'd7,  1'b1, 32'h55};
        vecs[4] = '{1'b1, 5'd0,  32'h1,        1'b1, 5'd9,  32'h99,       5'd0,  1'b0, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hA5A5A5A5, 1'b1, 5'd1,  32'h12345678, 5'd31, 1'b1, 32'hA5A5A5A5};
        vecs[6] = '{1'b1, 5'd6,  32'h66,       1'b0, 5'd0,  32'h0,        5'd8,  1'b0, 32'h0};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h77,       5'd0,  1'b0, 32'h0};

        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            // EXU wins the first tie after reset in both policies
            if (vecs[i].ev && vecs[i].ea != 5'd0) exp_q.push_back('{vecs[i].ea, vecs[i].ed});
            if (vecs[i].lv && vecs[i].la != 5'd0) exp_q.push_back('{vecs[i].la, vecs[i].ld});
            exu_valid = vecs[i].ev;
            exu_addr  = vecs[i].ea;
            exu_data  = vecs[i].ed;
            lsu_valid = vecs[i].lv;
            lsu_addr  = vecs[i].la;
            lsu_data  = vecs[i].ld;
            q_addr    = vecs[i].qa;
            @(posedge clk);
            #1;
            idle_inputs();
            @(negedge clk);
            chk($sformatf("v%0d_q_hit", i), 64'(q_hit), 64'(vecs[i].qhit));
            chk($sformatf("v%0d_q_data", i), 64'(q_data), 64'(vecs[i].qdata));
            drain();
        end

        // Single write latency: w_en high only for the cycle after T1
        do_reset();
        exp_q.push_back('{5'd5, 32'hDEADBEEF});
        exu_valid = 1'b1;
        exu_addr  = 5'd5;
        exu_data  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("lat_t0_w_en", 64'(gpr_w_en), 64'd0);
        @(negedge clk);
        chk("lat_t1_w_en", 64'(gpr_w_en), 64'd1);
        chk("lat_t1_addr", 64'(gpr_w_addr), 64'd5);
        chk("lat_t1_data", 64'(gpr_w_data), 64'hDEADBEEF);
        @(negedge clk);
        chk("lat_t2_w_en", 64'(gpr_w_en), 64'd0);
        drain();

        // Both stream 4 writes: alternation with RR, EXU first otherwise
        do_reset();
        exu_src.delete();
        lsu_src.delete();
        for (int k = 0; k < 4; k++) begin
            exu_src.push_back('{5'(1 + k), 32'h1000 + 32'(k)});
            lsu_src.push_back('{5'(8 + k), 32'h8000 + 32'(k)});
        end
`ifdef GPR_WB_RR_EN
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(exu_src[k]);
            exp_q.push_back(lsu_src[k]);
        end
`else
        for (int k = 0; k < 4; k++) exp_q.push_back(exu_src[k]);
        for (int k = 0; k < 4; k++) exp_q.push_back(lsu_src[k]);
`endif
        win_base = wr_count;
        stream(1'b0);
        drain();
        chk("stream_write_count", 64'(wr_count - win_base), 64'd8);
        chk("stream_back_to_back", 64'(win_last - win_first), 64'd7);

`ifndef GPR_WB_RR_EN
        // Continuous EXU stream starves LSU under fixed priority
        do_reset();
        exu_src.delete();
        lsu_src.delete();
        for (int k = 0; k < 10; k++) exu_src.push_back('{5'(1 + k), 32'hE000 + 32'(k)});
        lsu_src.push_back('{5'd20, 32'h2020});
        for (int k = 0; k < 10; k++) exp_q.push_back(exu_src[k]);
        exp_q.push_back(lsu_src[0]);
        stream(1'b1);
        drain();
`endif

        // Reset mid-flight drops the pending LSU write to x7
        do_reset();
        exp_q.push_back('{5'd2, 32'h2222});
        exu_valid = 1'b1;
        exu_addr  = 5'd2;
        exu_data  = 32'h2222;
        lsu_valid = 1'b1;
        lsu_addr  = 5'd7;
        lsu_data  = 32'h55;
        q_addr    = 5'd7;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("mid_q_hit_buf", 64'(q_hit), 64'd1);
        chk("mid_q_data_buf", 64'(q_data), 64'h55);
        @(negedge clk);
        chk("mid_w_en_before_rst", 64'(gpr_w_en), 64'd1);
        chk("mid_q_hit_still", 64'(q_hit), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_w_en_async_drop", 64'(gpr_w_en), 64'd0);
        chk("mid_q_hit_after_rst", 64'(q_hit), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mid_q_hit_released", 64'(q_hit), 64'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
